// File: rtl/window_3x3_generator_if.sv
// Pixel-stream in / 3x3-window out bundle for window_3x3_generator.
// The master drives the raster pixels and the slave returns the windows.
interface window_3x3_generator_if;
    logic [11:0]  pixel_in;
    logic         pixel_valid;
    logic         frame_start;
    logic [107:0] color_data;
    logic         window_valid;
    logic [15:0]  center_x;
    logic [15:0]  center_y;

    modport master (
        output pixel_in,
        output pixel_valid,
        output frame_start,
        input  color_data,
        input  window_valid,
        input  center_x,
        input  center_y
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        input  frame_start,
        output color_data,
        output window_valid,
        output center_x,
        output center_y
    );
endinterface

// File: rtl/window_3x3_generator.sv
// Streams raster RGB444 pixels through two line buffers and a 3x3 register window,
// emitting one window per interior pixel together with its center coordinates.
module window_3x3_generator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    window_3x3_generator_if.slave         io_win
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [11:0]   r_line1 [IMG_WIDTH];
    logic [11:0]   r_line2 [IMG_WIDTH];
    logic [11:0]   r_win   [3][3];
    logic          r_valid;
    logic [15:0]   r_cx;
    logic [15:0]   r_cy;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_colLast;
    logic          w_rowLast;
    logic [11:0]   w_top;
    logic [11:0]   w_mid;
    logic          w_emit;

    // frame_start redefines the pixel on this edge as (0,0) of a new frame
    assign w_col     = io_win.frame_start ? '0 : r_col;
    assign w_row     = io_win.frame_start ? '0 : r_row;
    assign w_colLast = (w_col == CW'(IMG_WIDTH - 1));
    assign w_rowLast = (w_row == RW'(IMG_HEIGHT - 1));
    assign w_top     = r_line2[w_col];
    assign w_mid     = r_line1[w_col];
    assign w_emit    = io_win.pixel_valid && (w_col >= CW'(2)) && (w_row >= RW'(2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (io_win.pixel_valid) begin
            if (w_colLast) begin
                r_col <= '0;
                r_row <= w_rowLast ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end else if (io_win.frame_start) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // Line buffers need no reset: rows 0 and 1 never produce a window
    always_ff @(posedge clk) begin
        if (reset && io_win.pixel_valid) begin
            r_line2[w_col] <= w_mid;
            r_line1[w_col] <= io_win.pixel_in;
        end
    end

    // Window rows: 0 = two lines up, 1 = previous line, 2 = current line; column 2 is newest
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_valid <= 1'b0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_valid <= w_emit;
            if (io_win.pixel_valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_top;
                r_win[1][2] <= w_mid;
                r_win[2][2] <= io_win.pixel_in;
            end
            if (w_emit) begin
                r_cx <= 16'(w_col) - 16'd1;
                r_cy <= 16'(w_row) - 16'd1;
            end
        end
    end

    assign io_win.color_data   = {r_win[1][1], r_win[1][0], r_win[1][2],
                                  r_win[0][1], r_win[2][1],
                                  r_win[0][0], r_win[0][2],
                                  r_win[2][0], r_win[2][2]};
    assign io_win.window_valid = r_valid;
    assign io_win.center_x     = r_cx;
    assign io_win.center_y     = r_cy;

endmodule
